// File: rtl/chimp_board_loader.sv
// chimp_board_loader: clears the board RAM, then scatters tiles 1..L onto free cells picked by a
// Galois LFSR with linear probing. Define CHIMP_LOADER_STATS_EN to add the oRetries counter.
module chimp_board_loader #(
   parameter int GRID_CELLS = 40
) (
   input  logic        clk,
   input  logic        iReset,
   input  logic        iStart,
   input  logic [4:0]  iLevel,
   input  logic [15:0] iSeed,
   input  logic        iAbort,
   output logic        oBusy,
   output logic        oDone,
   output logic        oWrEn,
   output logic [5:0]  oWrAddr,
   output logic [4:0]  oWrData
`ifdef CHIMP_LOADER_STATS_EN
   ,
   output logic [7:0]  oRetries
`endif
);

   localparam logic [5:0]  LP_GRID      = 6'(GRID_CELLS);
   localparam logic [5:0]  LP_LAST      = 6'(GRID_CELLS - 1);
   localparam logic [15:0] LP_LFSR_INIT = 16'hACE1;
   localparam logic [15:0] LP_TAPS      = 16'hB400;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_PICK,
      S_PROBE,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_lfsr;
   logic [4:0]  r_level;
   logic [4:0]  r_tile;
   logic [5:0]  r_clrAddr;
   logic [5:0]  r_probe;
   logic [63:0] r_occ;

   logic [15:0] w_lfsrStep;
   logic [15:0] w_seedMix;
   logic [15:0] w_seedLoad;
   logic [5:0]  w_candRaw;
   logic [5:0]  w_cand;
   logic [5:0]  w_target;
   logic [5:0]  w_targetNext;
   logic        w_seek;
   logic        w_hit;
   logic        w_place;
   logic        w_accept;
   logic        w_lastTile;
   logic        w_wrEn;
   logic [5:0]  w_wrAddr;
   logic [4:0]  w_wrData;
   logic        w_done;

   assign w_lfsrStep   = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LP_TAPS : 16'h0000);
   assign w_seedMix    = r_lfsr ^ iSeed;
   assign w_seedLoad   = (w_seedMix == 16'h0000) ? LP_LFSR_INIT : w_seedMix;
   assign w_candRaw    = r_lfsr[5:0];
   assign w_cand       = (w_candRaw >= LP_GRID) ? (w_candRaw - LP_GRID) : w_candRaw;
   // PICK looks at the fresh candidate, PROBE at the latched probe pointer; both advance the same way
   assign w_target     = (r_state == S_PROBE) ? r_probe : w_cand;
   assign w_targetNext = (w_target == LP_LAST) ? 6'd0 : (w_target + 6'd1);
   assign w_seek       = (r_state == S_PICK) || (r_state == S_PROBE);
   assign w_hit        = w_seek && r_occ[w_target];
   assign w_place      = w_seek && !r_occ[w_target] && !iAbort;
   assign w_accept     = (r_state == S_IDLE) && iStart && !iAbort;
   assign w_lastTile   = (r_tile == r_level);

   always_comb begin
      w_next   = r_state;
      w_wrEn   = 1'b0;
      w_wrAddr = 6'd0;
      w_wrData = 5'd0;
      w_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (iStart) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            w_wrEn   = 1'b1;
            w_wrAddr = r_clrAddr;
            if (r_clrAddr == LP_LAST) w_next = (r_level == 5'd0) ? S_DONE : S_PICK;
         end
         S_PICK, S_PROBE: begin
            if (!r_occ[w_target]) begin
               w_wrEn   = 1'b1;
               w_wrAddr = w_target;
               w_wrData = r_tile;
               w_next   = w_lastTile ? S_DONE : S_PICK;
            end else begin
               w_next = S_PROBE;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // an abort suppresses the strobes of the cycle it arrives in, so nothing more reaches the RAM
      if (iAbort) begin
         w_next   = S_IDLE;
         w_wrEn   = 1'b0;
         w_wrAddr = 6'd0;
         w_wrData = 5'd0;
         w_done   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge iReset) begin
      if (iReset) begin
         r_state   <= S_IDLE;
         r_lfsr    <= LP_LFSR_INIT;
         r_level   <= 5'd0;
         r_tile    <= 5'd0;
         r_clrAddr <= 6'd0;
         r_probe   <= 6'd0;
         r_occ     <= 64'd0;
      end else begin
         r_state <= w_next;
         r_lfsr  <= w_accept ? w_seedLoad : w_lfsrStep;
         if (w_accept) begin
            r_level   <= iLevel;
            r_clrAddr <= 6'd0;
         end
         if (r_state == S_CLEAR) begin
            r_occ[r_clrAddr] <= 1'b0;
            r_clrAddr        <= r_clrAddr + 6'd1;
            r_tile           <= 5'd1;
         end
         if (w_place) begin
            r_occ[w_target] <= 1'b1;
            if (!w_lastTile) r_tile <= r_tile + 5'd1;
         end
         if (w_hit) r_probe <= w_targetNext;
      end
   end

`ifdef CHIMP_LOADER_STATS_EN
   logic [7:0] r_retries;

   always_ff @(posedge clk or posedge iReset) begin
      if (iReset) begin
         r_retries <= 8'd0;
      end else if (w_accept) begin
         r_retries <= 8'd0;
      end else if (w_hit && !iAbort && (r_retries != 8'hFF)) begin
         r_retries <= r_retries + 8'd1;
      end
   end

   assign oRetries = r_retries;
`endif

   assign oBusy   = (r_state != S_IDLE);
   assign oDone   = w_done;
   assign oWrEn   = w_wrEn;
   assign oWrAddr = w_wrAddr;
   assign oWrData = w_wrData;

endmodule

// File: doc/chimp_board_loader.md
CHIMP_BOARD_LOADER -- requirements
Module: chimp_board_loader

Interface
REQ-001 SHALL have parameter GRID_CELLS, default 40, meaning number of board cells (legal 32..63).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port iReset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port iStart  input  1  request to build a new board; sampled only in IDLE.
REQ-005 SHALL have port iLevel  input  5  tiles to place (0..31); captured when iStart is accepted.
REQ-006 SHALL have port iSeed  input  16  entropy word XORed into the LFSR when iStart is accepted.
REQ-007 SHALL have port iAbort  input  1  synchronous abort back to IDLE (menu return).
REQ-008 SHALL have port oBusy  output  1  high in every state except IDLE.
REQ-009 SHALL have port oDone  output  1  one-cycle pulse when the board is complete.
REQ-010 SHALL have port oWrEn  output  1  board-RAM write strobe.
REQ-011 SHALL have port oWrAddr  output  6  board-RAM cell address.
REQ-012 SHALL have port oWrData  output  5  tile number written; 0 means empty cell.

Function
REQ-013 SHALL implement states IDLE, CLEAR, PICK, PROBE and DONE.
REQ-014 IDLE: SHALL, on iStart=1 and iAbort=0, capture iLevel, apply lfsr^iSeed (forced to 16'hACE1 if zero), zero the clear address, and enter CLEAR; otherwise SHALL stay in IDLE.
REQ-015 CLEAR: SHALL write data 0 to addresses 0..GRID_CELLS-1, one per cycle, and clear bit i of the 64-bit occupancy map in the same cycle; after the last address it SHALL enter PICK with tile counter=1, or DONE if the captured level is 0.
REQ-016 The LFSR SHALL be 16-bit Galois with polynomial x^16+x^14+x^13+x^11+1 and SHALL advance every cycle in every state.
REQ-017 PICK: candidate SHALL be lfsr[5:0], reduced by GRID_CELLS if it is >= GRID_CELLS.
REQ-018 PICK: SHALL write the tile counter to a free candidate in the same cycle and mark it occupied; if the candidate is occupied, it SHALL write nothing, latch (candidate+1) mod GRID_CELLS and enter PROBE.
REQ-019 PROBE: SHALL linearly probe one cell per cycle with wrap from GRID_CELLS-1 to 0, writing the tile counter at the first free cell.
REQ-020 After any tile write, SHALL enter DONE if the counter equals the level; otherwise SHALL increment the counter and enter PICK.
REQ-021 DONE: SHALL assert oDone for exactly one cycle and then return to IDLE.
REQ-022 Latency from the accepting edge to oDone SHALL be GRID_CELLS+L+1 cycles plus one cycle per probed occupied cell, where L is the captured level.
REQ-023 oWrEn SHALL be 0 in IDLE and DONE, and in any PICK or PROBE cycle that finds the cell occupied.
REQ-024 iAbort=1 in any state SHALL force IDLE on the next edge with no oDone and no further writes; iAbort SHALL win over a simultaneous iStart.
REQ-025 iStart while oBusy=1 SHALL be ignored.
REQ-026 No two tiles SHALL ever be written to the same cell within one load.

Reset
REQ-027 iReset=1 SHALL immediately force IDLE, lfsr=16'hACE1, counter=0, occupancy=0, oBusy=0, oDone=0, oWrEn=0, oWrAddr=0 and oWrData=0, regardless of clk, including mid-load.

Configuration
REQ-028 With CHIMP_LOADER_STATS_EN defined, the block SHALL add an output oRetries (8 bits) that counts occupied cells hit in PICK or PROBE during the current load; it SHALL saturate at 255, clear on start acceptance, and hold its value after DONE.
REQ-029 Without CHIMP_LOADER_STATS_EN, the oRetries port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then iStart with iLevel=0 -> 40 writes of data 0 to addresses 0..39, oDone on cycle 41, no tile writes.
REQ-031 iStart with iLevel=5 and iSeed=16'h0000 -> exactly five tile writes with data 1..5 to distinct addresses <40, and oDone on cycle 46 plus the probe count.
REQ-032 Preload occupancy so that PICK hits cell 39 occupied and cell 0 is free -> PROBE writes address 0 (wrap), and oRetries=1 when the macro is on.
REQ-033 iLevel=31 over 20 random seeds -> 31 distinct addresses per load and oDone exactly once per load.
REQ-034 iAbort during CLEAR at address 17, and separately iReset asserted between edges during PICK -> IDLE reached, no oDone, oWrEn=0 afterward, reset outputs seen within the same cycle.
REQ-035 iStart held high during a load, and iStart with iAbort asserted together -> the held start is ignored until IDLE, and the simultaneous pair leaves the block in IDLE.
